// File: rtl/game_pkg.sv
// Shared types and constants for the Triangles-vs-Circles sequencer.
// Cell/reject encodings, FSM states and scan directions with dx/dy lookup.
package game_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_TRI   = 2'b01;
    localparam logic [1:0] CELL_CIRC  = 2'b10;

    localparam logic [1:0] REJ_RANGE  = 2'b01;
    localparam logic [1:0] REJ_OCC    = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_COORD,
        ST_SCAN,
        ST_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        DIR_H,
        DIR_V,
        DIR_D,
        DIR_A
    } dir_t;

    function automatic logic signed [5:0] dir_dx(input dir_t d);
        return (d == DIR_V) ? 6'sd0 : 6'sd1;
    endfunction

    function automatic logic signed [5:0] dir_dy(input dir_t d);
        logic signed [5:0] r;
        case (d)
            DIR_H:   r = 6'sd0;
            DIR_A:   r = -6'sd1;
            default: r = 6'sd1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/line_scanner.sv
// Walks the four lines through the last move, one probe per cycle.
// Ports: start/org_x/org_y/player load a scan; probe_x/probe_y address
// the board, probe_cell returns it; done pulses at the end, win with it.
module line_scanner
    import game_pkg::*;
#(
    parameter int GRID    = 10,
    parameter int WIN_LEN = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] org_x,
    input  logic [3:0] org_y,
    input  logic [1:0] player,
    input  logic [1:0] probe_cell,
    output logic [3:0] probe_x,
    output logic [3:0] probe_y,
    output logic       done,
    output logic       win
);

    localparam logic signed [5:0] EDGE  = 6'(GRID);
    localparam logic [4:0]        WIN_L = 5'(WIN_LEN);
    localparam logic [3:0]        K_MAX = 4'(WIN_LEN - 1);

    logic              active_q, active_d;
    dir_t              dir_q, dir_d, nxt_dir;
    logic              sense_q, sense_d;
    logic [3:0]        k_q, k_d;
    logic [4:0]        cnt_q, cnt_d, cnt_inc;
    logic signed [5:0] cx_q, cx_d, cy_q, cy_d;
    logic signed [5:0] ox_q, ox_d, oy_q, oy_d;
    logic signed [5:0] sx, sy, nx, ny;
    logic              match, adv;

    function automatic logic on_grid(input logic signed [5:0] x,
                                     input logic signed [5:0] y);
        return (x >= 6'sd0) && (x < EDGE) && (y >= 6'sd0) && (y < EDGE);
    endfunction

    assign probe_x = cx_q[3:0];
    assign probe_y = cy_q[3:0];

    always_comb begin
        sx       = sense_q ? -dir_dx(dir_q) : dir_dx(dir_q);
        sy       = sense_q ? -dir_dy(dir_q) : dir_dy(dir_q);
        nx       = cx_q + sx;
        ny       = cy_q + sy;
        match    = on_grid(cx_q, cy_q) && (probe_cell == player);
        cnt_inc  = cnt_q + 5'd1;
        nxt_dir  = dir_t'(dir_q + 2'd1);
        active_d = active_q;
        dir_d    = dir_q;
        sense_d  = sense_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        done     = 1'b0;
        win      = 1'b0;
        adv      = 1'b0;
        if (start) begin
            active_d = 1'b1;
            dir_d    = DIR_H;
            sense_d  = 1'b0;
            k_d      = 4'd0;
            cnt_d    = 5'd1;
            ox_d     = signed'({2'b00, org_x});
            oy_d     = signed'({2'b00, org_y});
            cx_d     = signed'({2'b00, org_x}) + 6'sd1;
            cy_d     = signed'({2'b00, org_y});
        end else if (active_q) begin
            if (match) begin
                if (cnt_inc >= WIN_L) begin
                    done     = 1'b1;
                    win      = 1'b1;
                    active_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    k_d   = k_q + 4'd1;
                    // leave the sense now rather than burn a cycle on a
                    // probe we already know cannot count
                    if (k_d == K_MAX || !on_grid(nx, ny)) begin
                        adv = 1'b1;
                    end else begin
                        cx_d = nx;
                        cy_d = ny;
                    end
                end
            end else begin
                adv = 1'b1;
            end
            if (adv) begin
                k_d = 4'd0;
                if (!sense_q) begin
                    sense_d = 1'b1;
                    cx_d    = ox_q - dir_dx(dir_q);
                    cy_d    = oy_q - dir_dy(dir_q);
                end else if (dir_q == DIR_A) begin
                    done     = 1'b1;
                    active_d = 1'b0;
                end else begin
                    dir_d   = nxt_dir;
                    sense_d = 1'b0;
                    cnt_d   = 5'd1;
                    cx_d    = ox_q + dir_dx(nxt_dir);
                    cy_d    = oy_q + dir_dy(nxt_dir);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            dir_q    <= DIR_H;
            sense_q  <= 1'b0;
            k_q      <= 4'd0;
            cnt_q    <= 5'd0;
            cx_q     <= 6'sd0;
            cy_q     <= 6'sd0;
            ox_q     <= 6'sd0;
            oy_q     <= 6'sd0;
        end else begin
            active_q <= active_d;
            dir_q    <= dir_d;
            sense_q  <= sense_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
        end
    end

endmodule

// File: rtl/turn_controller.sv
// Turn sequencer: board, move legality, turn/counters, win/draw FSM.
// In: start, coord_valid/x_in/y_in, rd_x/rd_y. Out: rd_cell, turn,
// move_accept/move_reject/reject_code, busy, game_over, winner, draw,
// tri_moves/circ_moves. Macro TURN_TIMEOUT_EN adds turn_timeout.
module turn_controller
    import game_pkg::*;
#(
    parameter int GRID           = 10,
    parameter int WIN_LEN        = 4,
    parameter int TIMEOUT_CYCLES = 500000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       coord_valid,
    input  logic [3:0] x_in,
    input  logic [3:0] y_in,
    input  logic [3:0] rd_x,
    input  logic [3:0] rd_y,
    output logic [1:0] rd_cell,
    output logic       turn,
    output logic       move_accept,
    output logic       move_reject,
    output logic [1:0] reject_code,
    output logic       busy,
    output logic       game_over,
    output logic [1:0] winner,
    output logic       draw,
    output logic [6:0] tri_moves,
    output logic [6:0] circ_moves
`ifdef TURN_TIMEOUT_EN
    ,
    output logic       turn_timeout
`endif
);

    localparam int         NCELL = GRID * GRID;
    localparam logic [3:0] EDGE  = 4'(GRID);
    localparam logic [7:0] FULL  = 8'(NCELL);

    state_t     state_q, state_d;
    logic [1:0] board_q [NCELL];
    logic [1:0] board_d [NCELL];
    logic       turn_q, turn_d;
    logic       acc_q, acc_d, rej_q, rej_d;
    logic [1:0] code_q, code_d, win_q, win_d;
    logic       draw_q, draw_d;
    logic [6:0] tri_q, tri_d, circ_q, circ_d;
    logic       new_game, in_range;
    logic       scan_start, scan_done, scan_win;
    logic [3:0] probe_x, probe_y;
    logic [1:0] probe_cell, player;
    logic [7:0] total;
    int         tgt_idx, rd_idx, pr_idx;

`ifdef TURN_TIMEOUT_EN
    localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_out_q, tmo_out_d;
    assign turn_timeout = tmo_out_q;
`endif

    assign player   = turn_q ? CELL_CIRC : CELL_TRI;
    assign in_range = (x_in < EDGE) && (y_in < EDGE);
    assign tgt_idx  = int'(y_in) * GRID + int'(x_in);
    assign rd_idx   = int'(rd_y) * GRID + int'(rd_x);
    assign pr_idx   = int'(probe_y) * GRID + int'(probe_x);
    assign total    = {1'b0, tri_q} + {1'b0, circ_q};

    assign rd_cell = ((rd_x < EDGE) && (rd_y < EDGE)) ?
                     board_q[rd_idx] : CELL_EMPTY;
    assign probe_cell = ((probe_x < EDGE) && (probe_y < EDGE)) ?
                        board_q[pr_idx] : CELL_EMPTY;

    line_scanner #(
        .GRID    (GRID),
        .WIN_LEN (WIN_LEN)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .start      (scan_start),
        .org_x      (x_in),
        .org_y      (y_in),
        .player     (player),
        .probe_cell (probe_cell),
        .probe_x    (probe_x),
        .probe_y    (probe_y),
        .done       (scan_done),
        .win        (scan_win)
    );

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        acc_d      = 1'b0;
        rej_d      = 1'b0;
        code_d     = code_q;
        win_d      = win_q;
        draw_d     = draw_q;
        tri_d      = tri_q;
        circ_d     = circ_q;
        new_game   = 1'b0;
        scan_start = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tmo_out_d  = 1'b0;
        tmo_d      = '0;
        if (state_q == ST_WAIT_COORD && !coord_valid && tmo_q != TMO_LAST)
            tmo_d = tmo_q + 1'b1;
`endif
        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                new_game = start;
            end
            ST_WAIT_COORD: begin
                if (coord_valid) begin
                    if (!in_range) begin
                        rej_d  = 1'b1;
                        code_d = REJ_RANGE;
                    end else if (board_q[tgt_idx] != CELL_EMPTY) begin
                        rej_d  = 1'b1;
                        code_d = REJ_OCC;
                    end else begin
                        board_d[tgt_idx] = player;
                        acc_d      = 1'b1;
                        scan_start = 1'b1;
                        state_d    = ST_SCAN;
                        if (turn_q) circ_d = circ_q + 7'd1;
                        else        tri_d  = tri_q + 7'd1;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    tmo_out_d = 1'b1;
                    turn_d    = ~turn_q;
                end
`endif
            end
            ST_SCAN: begin
                if (scan_done) begin
                    if (scan_win) begin
                        win_d   = player;
                        state_d = ST_GAME_OVER;
                    end else if (total == FULL) begin
                        draw_d  = 1'b1;
                        state_d = ST_GAME_OVER;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_WAIT_COORD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (new_game) begin
            for (int i = 0; i < NCELL; i++) board_d[i] = CELL_EMPTY;
            turn_d  = 1'b0;
            win_d   = CELL_EMPTY;
            draw_d  = 1'b0;
            tri_d   = 7'd0;
            circ_d  = 7'd0;
            state_d = ST_WAIT_COORD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < NCELL; i++) board_q[i] <= CELL_EMPTY;
            turn_q  <= 1'b0;
            acc_q   <= 1'b0;
            rej_q   <= 1'b0;
            code_q  <= 2'b00;
            win_q   <= 2'b00;
            draw_q  <= 1'b0;
            tri_q   <= 7'd0;
            circ_q  <= 7'd0;
`ifdef TURN_TIMEOUT_EN
            tmo_q     <= '0;
            tmo_out_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            turn_q  <= turn_d;
            acc_q   <= acc_d;
            rej_q   <= rej_d;
            code_q  <= code_d;
            win_q   <= win_d;
            draw_q  <= draw_d;
            tri_q   <= tri_d;
            circ_q  <= circ_d;
`ifdef TURN_TIMEOUT_EN
            tmo_q     <= tmo_d;
            tmo_out_q <= tmo_out_d;
`endif
        end
    end

    assign turn        = turn_q;
    assign move_accept = acc_q;
    assign move_reject = rej_q;
    assign reject_code = code_q;
    assign busy        = (state_q == ST_SCAN);
    assign game_over   = (state_q == ST_GAME_OVER);
    assign winner      = win_q;
    assign draw        = draw_q;
    assign tri_moves   = tri_q;
    assign circ_moves  = circ_q;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: directed and random games on a 10x10/4
// and a 3x3/3 instance, checked against a board-level reference model.
module tb_turn_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       start [2];
    logic       coord_valid [2];
    logic [3:0] x_in [2], y_in [2], rd_x [2], rd_y [2];
    logic [1:0] rd_cell [2], reject_code [2], winner [2];
    logic       turn [2], move_accept [2], move_reject [2];
    logic       busy [2], game_over [2], draw [2];
    logic [6:0] tri_moves [2], circ_moves [2];
`ifdef TURN_TIMEOUT_EN
    logic       tt [2];
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int G [2] = '{10, 3};
    int W [2] = '{4, 3};
    int bd [2][16][16];
    int m_state [2];
    int m_turn [2], m_tri [2], m_circ [2];
    int m_win [2], m_draw [2], m_code [2];

    always #5 clk = ~clk;

    turn_controller #(.GRID(10), .WIN_LEN(4)) dut0 (
        .clk(clk), .reset(reset), .start(start[0]),
        .coord_valid(coord_valid[0]), .x_in(x_in[0]), .y_in(y_in[0]),
        .rd_x(rd_x[0]), .rd_y(rd_y[0]), .rd_cell(rd_cell[0]),
        .turn(turn[0]), .move_accept(move_accept[0]),
        .move_reject(move_reject[0]), .reject_code(reject_code[0]),
        .busy(busy[0]), .game_over(game_over[0]), .winner(winner[0]),
        .draw(draw[0]), .tri_moves(tri_moves[0]),
        .circ_moves(circ_moves[0])
`ifdef TURN_TIMEOUT_EN
        , .turn_timeout(tt[0])
`endif
    );

    turn_controller #(.GRID(3), .WIN_LEN(3)) dut1 (
        .clk(clk), .reset(reset), .start(start[1]),
        .coord_valid(coord_valid[1]), .x_in(x_in[1]), .y_in(y_in[1]),
        .rd_x(rd_x[1]), .rd_y(rd_y[1]), .rd_cell(rd_cell[1]),
        .turn(turn[1]), .move_accept(move_accept[1]),
        .move_reject(move_reject[1]), .reject_code(reject_code[1]),
        .busy(busy[1]), .game_over(game_over[1]), .winner(winner[1]),
        .draw(draw[1]), .tri_moves(tri_moves[1]),
        .circ_moves(circ_moves[1])
`ifdef TURN_TIMEOUT_EN
        , .turn_timeout(tt[1])
`endif
    );

    function automatic bit m_wins(int d, int x, int y, int p);
        int dxs [4] = '{1, 0, 1, 1};
        int dys [4] = '{0, 1, 1, -1};
        int c, cx, cy;
        for (int k = 0; k < 4; k++) begin
            c = 1;
            for (int s = -1; s <= 1; s += 2) begin
                cx = x + s * dxs[k];
                cy = y + s * dys[k];
                while (cx >= 0 && cx < G[d] && cy >= 0 && cy < G[d]
                       && bd[d][cx][cy] == p) begin
                    c++;
                    cx += s * dxs[k];
                    cy += s * dys[k];
                end
            end
            if (c >= W[d]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_new_game(input int d);
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++) bd[d][x][y] = 0;
        m_turn[d] = 0; m_tri[d] = 0; m_circ[d] = 0;
        m_win[d]  = 0; m_draw[d] = 0;
    endtask

    task automatic count_cells(input int d, output int n);
        n = 0;
        for (int x = 0; x < G[d]; x++)
            for (int y = 0; y < G[d]; y++) begin
                rd_x[d] = 4'(x); rd_y[d] = 4'(y); #1;
                if (rd_cell[d] !== 2'b00) n++;
            end
    endtask

    task automatic check_zero(input string tag);
        logic [23:0] obs;
        int n;
        for (int d = 0; d < 2; d++) begin
            obs = {turn[d], move_accept[d], move_reject[d], reject_code[d],
                   busy[d], game_over[d], winner[d], draw[d],
                   tri_moves[d], circ_moves[d]};
            n_tests++;
            if (obs !== 24'h0) begin
                n_fail++;
                $display("FAIL %s_outputs d%0d got %h want 0", tag, d, obs);
            end
            count_cells(d, n);
            n_tests++;
            if (n != 0) begin
                n_fail++;
                $display("FAIL %s_board d%0d cells %0d want 0", tag, d, n);
            end
        end
    endtask

    task automatic reset_all;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; coord_valid[d] = 0;
            x_in[d] = 0; y_in[d] = 0; rd_x[d] = 0; rd_y[d] = 0;
            model_new_game(d);
            m_state[d] = 0; m_code[d] = 0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic do_start(input int d, input int cv, input int x,
                            input int y);
        @(negedge clk);
        start[d] = 1'b1;
        if (cv != 0) begin
            coord_valid[d] = 1'b1; x_in[d] = 4'(x); y_in[d] = 4'(y);
        end
        if (m_state[d] != 1) begin
            model_new_game(d);
            m_state[d] = 1;
        end
        @(posedge clk); #1;
        start[d] = 1'b0; coord_valid[d] = 1'b0;
        n_tests++;
        if ({game_over[d], winner[d], draw[d], turn[d]} !==
            {m_state[d] == 2, 2'(m_win[d]), m_draw[d] != 0,
             m_turn[d] != 0}) begin
            n_fail++;
            $display("FAIL start_state d%0d got %b%b%b%b", d, game_over[d],
                     winner[d], draw[d], turn[d]);
        end
        n_tests++;
        if ({tri_moves[d], circ_moves[d]} !==
            {7'(m_tri[d]), 7'(m_circ[d])}) begin
            n_fail++;
            $display("FAIL start_counts d%0d got %0d/%0d want %0d/%0d", d,
                     tri_moves[d], circ_moves[d], m_tri[d], m_circ[d]);
        end
        if (cv != 0) begin
            n_tests++;
            if ({move_accept[d], move_reject[d]} !== 2'b00) begin
                n_fail++;
                $display("FAIL start_drops_coord d%0d got %b%b want 00", d,
                         move_accept[d], move_reject[d]);
            end
        end
    endtask

    task automatic do_move(input int d, input int x, input int y);
        int acc, rej, p, n, ecell;
        acc = 0; rej = 0; p = 0;
        @(negedge clk);
        x_in[d] = 4'(x); y_in[d] = 4'(y); coord_valid[d] = 1'b1;
        if (m_state[d] == 1) begin
            if (x >= G[d] || y >= G[d]) begin
                rej = 1; m_code[d] = 1;
            end else if (bd[d][x][y] != 0) begin
                rej = 1; m_code[d] = 2;
            end else begin
                acc = 1; p = m_turn[d] + 1; bd[d][x][y] = p;
                if (p == 1) m_tri[d]++;
                else m_circ[d]++;
            end
        end
        @(posedge clk); #1;
        coord_valid[d] = 1'b0;
        n_tests++;
        if ({move_accept[d], move_reject[d]} !== {acc[0], rej[0]}) begin
            n_fail++;
            $display("FAIL pulses d%0d (%0d,%0d) got %b%b want %b%b", d, x,
                     y, move_accept[d], move_reject[d], acc[0], rej[0]);
        end
        n_tests++;
        if (reject_code[d] !== 2'(m_code[d])) begin
            n_fail++;
            $display("FAIL reject_code d%0d got %b want %b", d,
                     reject_code[d], 2'(m_code[d]));
        end
        n_tests++;
        if (busy[d] !== acc[0]) begin
            n_fail++;
            $display("FAIL busy d%0d got %b want %b", d, busy[d], acc[0]);
        end
        if (acc != 0) begin
            n = 0;
            while (busy[d] === 1'b1 && n <= 8 * (W[d] - 1)) begin
                @(negedge clk); n++;
            end
            n_tests++;
            if (busy[d] !== 1'b0) begin
                n_fail++;
                $display("FAIL scan_cycles d%0d busy %b after %0d", d,
                         busy[d], n);
            end
            if (m_wins(d, x, y, p)) begin
                m_win[d] = p; m_state[d] = 2;
            end else if (m_tri[d] + m_circ[d] == G[d] * G[d]) begin
                m_draw[d] = 1; m_state[d] = 2;
            end else begin
                m_turn[d] ^= 1;
            end
        end else begin
            @(negedge clk);
        end
        rd_x[d] = 4'(x); rd_y[d] = 4'(y); #1;
        ecell = (x < G[d] && y < G[d]) ? bd[d][x][y] : 0;
        n_tests++;
        if (rd_cell[d] !== 2'(ecell)) begin
            n_fail++;
            $display("FAIL rd_cell d%0d (%0d,%0d) got %b want %b", d, x, y,
                     rd_cell[d], 2'(ecell));
        end
        n_tests++;
        if ({turn[d], game_over[d], winner[d], draw[d]} !==
            {m_turn[d] != 0, m_state[d] == 2, 2'(m_win[d]),
             m_draw[d] != 0}) begin
            n_fail++;
            $display("FAIL status d%0d got t%b o%b w%b d%b", d, turn[d],
                     game_over[d], winner[d], draw[d]);
        end
        n_tests++;
        if ({tri_moves[d], circ_moves[d]} !==
            {7'(m_tri[d]), 7'(m_circ[d])}) begin
            n_fail++;
            $display("FAIL move_counts d%0d got %0d/%0d want %0d/%0d", d,
                     tri_moves[d], circ_moves[d], m_tri[d], m_circ[d]);
        end
    endtask

    task automatic test_reset;
        reset_all();
        check_zero("reset");
    endtask

    task automatic test_idle_ignore;
        do_move(0, 3, 3);
        do_move(1, 1, 1);
    endtask

    task automatic test_basic;
        do_start(0, 0, 0, 0);
        do_move(0, 3, 3);
        n_tests++;
        if ({turn[0], tri_moves[0]} !== {1'b1, 7'd1}) begin
            n_fail++;
            $display("FAIL first_move got t%b n%0d want t1 n1", turn[0],
                     tri_moves[0]);
        end
        do_move(0, 3, 3);
        n_tests++;
        if ({reject_code[0], turn[0]} !== {2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL occupied got %b/%b want 10/1", reject_code[0],
                     turn[0]);
        end
        do_move(0, 12, 0);
        n_tests++;
        if (reject_code[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL out_of_range got %b want 01", reject_code[0]);
        end
        do_start(0, 0, 0, 0);
        do_move(0, 4, 4);
    endtask

    task automatic test_row_win;
        int tx [4] = '{0, 1, 2, 3};
        reset_all();
        do_start(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_move(0, tx[i], 0);
            if (i < 3) do_move(0, i, 5);
        end
        n_tests++;
        if ({winner[0], game_over[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL row_win got w%b o%b want w01 o1", winner[0],
                     game_over[0]);
        end
        do_move(0, 5, 5);
    endtask

    task automatic test_antidiag;
        int tx [4] = '{3, 2, 0, 1};
        int ty [4] = '{0, 1, 3, 2};
        int cx [3] = '{5, 6, 8};
        int wx [4] = '{8, 9, 0, 1};
        int wy [4] = '{0, 0, 1, 1};
        do_start(0, 1, 5, 5);
        rd_x[0] = 4'd5; rd_y[0] = 4'd5; #1;
        n_tests++;
        if (rd_cell[0] !== 2'b00) begin
            n_fail++;
            $display("FAIL start_over_coord cell got %b want 00", rd_cell[0]);
        end
        for (int i = 0; i < 4; i++) begin
            do_move(0, tx[i], ty[i]);
            if (i < 3) do_move(0, cx[i], cx[i]);
        end
        n_tests++;
        if ({winner[0], game_over[0]} !== 3'b011) begin
            n_fail++;
            $display("FAIL antidiag_win got w%b o%b want w01 o1", winner[0],
                     game_over[0]);
        end
        do_start(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            do_move(0, wx[i], wy[i]);
            if (i < 3) do_move(0, 5, 5 + 2 * i);
        end
        n_tests++;
        if ({winner[0], game_over[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL edge_wrap got w%b o%b want w00 o0", winner[0],
                     game_over[0]);
        end
    endtask

    task automatic test_draw;
        int mx [9] = '{0, 1, 2, 1, 0, 0, 2, 2, 1};
        int my [9] = '{0, 0, 0, 1, 1, 2, 1, 2, 2};
        int n;
        reset_all();
        do_start(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) do_move(1, mx[i], my[i]);
        n_tests++;
        if ({draw[1], winner[1], game_over[1]} !== 4'b1001) begin
            n_fail++;
            $display("FAIL draw got d%b w%b o%b want d1 w00 o1", draw[1],
                     winner[1], game_over[1]);
        end
        do_start(1, 0, 0, 0);
        count_cells(1, n);
        n_tests++;
        if (n != 0 || {turn[1], tri_moves[1], circ_moves[1]} !== 15'd0)
        begin
            n_fail++;
            $display("FAIL restart cells %0d t%b n%0d/%0d want all 0", n,
                     turn[1], tri_moves[1], circ_moves[1]);
        end
    endtask

    task automatic test_random;
        int n, x, y;
        for (int g = 0; g < 4; g++) begin
            reset_all();
            for (int d = 0; d < 2; d++) begin
                do_start(d, 0, 0, 0);
                n = 0;
                while (m_state[d] == 1 && n < 80) begin
                    if ($urandom_range(0, 7) == 0) begin
                        x = $urandom_range(0, 15);
                        y = $urandom_range(0, 15);
                    end else begin
                        x = $urandom_range(0, G[d] - 1);
                        y = $urandom_range(0, G[d] - 1);
                    end
                    do_move(d, x, y);
                    n++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan;
        reset_all();
        do_start(0, 0, 0, 0);
        do_move(0, 3, 3);
        @(negedge clk);
        x_in[0] = 4'd4; y_in[0] = 4'd4; coord_valid[0] = 1'b1;
        @(posedge clk); #1;
        coord_valid[0] = 1'b0;
        n_tests++;
        if (busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_scan_busy got %b want 1", busy[0]);
        end
        reset = 1'b1; #1;
        check_zero("mid_scan");
        for (int d = 0; d < 2; d++) begin
            model_new_game(d);
            m_state[d] = 0; m_code[d] = 0;
        end
        @(negedge clk);
        reset = 1'b0;
        do_move(0, 1, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_idle_ignore();
        test_basic();
        test_row_win();
        test_antidiag();
        test_draw();
        test_random();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
